// File: rtl/cp0_exception_unit_if.sv
// Signal bundle between the decode/datapath side and the CP0 exception sequencer.
// The master drives requests and register access; the slave is the sequencer.
interface cp0_exception_unit_if;
  logic        exc_req;
  logic        exc_code;
  logic [31:0] cur_pc;
  logic        irq;
  logic        eret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        status_exl;

  modport master (
    output exc_req, exc_code, cur_pc, irq, eret, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, flush, redirect_valid, redirect_pc, busy, status_exl
  );

  modport slave (
    input  exc_req, exc_code, cur_pc, irq, eret, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, flush, redirect_valid, redirect_pc, busy, status_exl
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception sequencer: records EPC/Cause/Status on exception,
// interrupt or ERET, then flushes the pipeline and issues a one-cycle PC redirect.
//
// state      | meaning
// S_IDLE     | accepting events and MTC0 writes
// S_FLUSH    | flush held high, counter runs down to zero
// S_REDIRECT | one-cycle redirect to the latched target
module cp0_exception_unit #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  cp0_exception_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_status;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_target;

  logic w_idle, w_take_exc, w_take_irq, w_take_eret, w_accept;

  // Priority: exception > interrupt > eret; irq and eret need opposite EXL so never collide.
  assign w_idle      = (r_state == S_IDLE);
  assign w_take_exc  = bus.exc_req;
  assign w_take_irq  = bus.irq & r_status[0] & ~r_status[1] & ~bus.exc_req;
  assign w_take_eret = bus.eret & r_status[1] & ~bus.exc_req & ~w_take_irq;
  assign w_accept    = w_idle & (w_take_exc | w_take_irq | w_take_eret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) w_state_nxt = S_REDIRECT;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status  <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
      r_target  <= '0;
    end else if (w_idle) begin
      if (w_take_exc) begin
        if (!r_status[1]) r_epc <= bus.cur_pc;
        r_exccode   <= bus.exc_code ? 5'h0A : 5'h0C;
        r_status[1] <= 1'b1;
        r_target    <= VECTOR_ADDR;
      end else if (w_take_irq) begin
        r_epc       <= bus.cur_pc;
        r_exccode   <= 5'h00;
        r_status[1] <= 1'b1;
        r_target    <= VECTOR_ADDR;
      end else if (w_take_eret) begin
        r_status[1] <= 1'b0;
        r_target    <= r_epc;
      end else if (bus.cp0_we) begin
        case (bus.cp0_addr)
          5'd12:   r_status  <= bus.cp0_wdata[1:0];
          5'd13:   r_exccode <= bus.cp0_wdata[6:2];
          5'd14:   r_epc     <= bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  // Cause.IP (bit 10) is the live irq level, never stored.
  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = {30'd0, r_status};
      5'd13:   bus.cp0_rdata = {21'd0, bus.irq, 3'd0, r_exccode, 2'd0};
      5'd14:   bus.cp0_rdata = r_epc;
      default: bus.cp0_rdata = '0;
    endcase
  end

  assign bus.flush          = (r_state == S_FLUSH);
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = (r_state == S_REDIRECT) ? r_target : 32'd0;
  assign bus.busy           = ~w_idle;
  assign bus.status_exl     = r_status[1];

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: scenario tasks check registers inline,
// a negedge monitor pops expected redirect targets from a scoreboard queue.
module tb_cp0_exception_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   flush_run = 0;
  logic [31:0] exp_q[$];

  cp0_exception_unit_if bus();

  cp0_exception_unit #(.VECTOR_ADDR(32'h0000_0080), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Redirect scoreboard and flush-length monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      flush_run = 0;
    end else begin
      if (bus.flush) begin
        flush_run++;
      end else if (flush_run != 0) begin
        checks++;
        if (flush_run != 2) begin
          errors++;
          $display("FAIL flush_len got %0d want 2", flush_run);
        end
        flush_run = 0;
      end
      if (bus.redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected got pc=%h want no redirect", bus.redirect_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.redirect_pc !== e) begin
            errors++;
            $display("FAIL redirect_pc got %h want %h", bus.redirect_pc, e);
          end
        end
      end else begin
        checks++;
        if (bus.redirect_pc !== 32'd0) begin
          errors++;
          $display("FAIL redirect_pc_idle got %h want 0", bus.redirect_pc);
        end
      end
    end
  end

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_addr = a;
    #1;
    d = bus.cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
    @(negedge clk);
    bus.cp0_we = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_idle got busy after %0d cycles want idle", n);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.flush, bus.redirect_valid, bus.busy, bus.status_exl} !== 4'b0 || bus.redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got f=%b rv=%b b=%b exl=%b pc=%h want all 0",
               bus.flush, bus.redirect_valid, bus.busy, bus.status_exl, bus.redirect_pc);
    end
    for (int a = 12; a <= 14; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int n;
    @(negedge clk);
    bus.exc_req = 1'b1; bus.exc_code = 1'b0; bus.cur_pc = 32'h40;
    exp_q.push_back(32'h80);
    @(negedge clk);
    bus.exc_req = 1'b0;
    checks++;
    if (bus.flush !== 1'b1 || bus.status_exl !== 1'b1) begin
      errors++; $display("FAIL ovf_entry got flush=%b exl=%b want 1 1", bus.flush, bus.status_exl);
    end
    rd(5'd14, d); checks++;
    if (d !== 32'h40) begin errors++; $display("FAIL ovf_epc got %h want 00000040", d); end
    rd(5'd13, d); checks++;
    if (d !== 32'h30) begin errors++; $display("FAIL ovf_cause got %h want 00000030", d); end
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL ovf_busy_len got %0d want 3", n); end
  endtask

  task automatic test_eret;
    int n;
    @(negedge clk);
    bus.eret = 1'b1;
    exp_q.push_back(32'h40);
    @(negedge clk);
    bus.eret = 1'b0;
    checks++;
    if (bus.status_exl !== 1'b0 || bus.flush !== 1'b1) begin
      errors++; $display("FAIL eret_entry got exl=%b flush=%b want 0 1", bus.status_exl, bus.flush);
    end
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL eret_busy_len got %0d want 3", n); end
    @(negedge clk);
    bus.eret = 1'b1;
    @(negedge clk);
    bus.eret = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.flush !== 1'b0) begin
      errors++; $display("FAIL eret_nop got busy=%b flush=%b want 0 0", bus.busy, bus.flush);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h1);
    rd(5'd12, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL irq_status_wr got %h want 00000001", d); end
    bus.irq = 1'b1; bus.cur_pc = 32'h100;
    exp_q.push_back(32'h80);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL irq_taken got busy=%b want 1", bus.busy); end
    rd(5'd14, d); checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL irq_epc got %h want 00000100", d); end
    rd(5'd13, d); checks++;
    if (d !== 32'h400) begin errors++; $display("FAIL irq_cause got %h want 00000400", d); end
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL irq_busy_len got %0d want 3", n); end
    bus.irq = 1'b0;
    mtc0(5'd12, 32'h0);
    bus.irq = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.status_exl !== 1'b0) begin
      errors++; $display("FAIL irq_masked got busy=%b exl=%b want 0 0", bus.busy, bus.status_exl);
    end
    bus.irq = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h1);
    bus.exc_req = 1'b1; bus.irq = 1'b1; bus.eret = 1'b1; bus.exc_code = 1'b1; bus.cur_pc = 32'h300;
    exp_q.push_back(32'h80);
    @(negedge clk);
    bus.exc_req = 1'b0; bus.eret = 1'b0;
    rd(5'd13, d); checks++;
    if (d !== 32'h428) begin errors++; $display("FAIL simul_cause got %h want 00000428", d); end
    rd(5'd14, d); checks++;
    if (d !== 32'h300) begin errors++; $display("FAIL simul_epc got %h want 00000300", d); end
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL simul_busy_len got %0d want 3", n); end
    bus.irq = 1'b0;
    rd(5'd13, d); checks++;
    if (d !== 32'h28) begin errors++; $display("FAIL simul_cause_noirq got %h want 00000028", d); end
  endtask

  task automatic test_nested;
    logic [31:0] d;
    int n;
    mtc0(5'd14, 32'h40);
    bus.exc_req = 1'b1; bus.exc_code = 1'b0; bus.cur_pc = 32'h200;
    exp_q.push_back(32'h80);
    @(negedge clk);
    bus.cur_pc = 32'h999;
    rd(5'd14, d); checks++;
    if (d !== 32'h40) begin errors++; $display("FAIL nested_epc got %h want 00000040", d); end
    rd(5'd13, d); checks++;
    if (d !== 32'h30) begin errors++; $display("FAIL nested_cause got %h want 00000030", d); end
    @(negedge clk);
    bus.exc_req = 1'b0;
    wait_idle(n); checks++;
    if (n != 2) begin errors++; $display("FAIL nested_busy_rest got %0d want 2", n); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL nested_flush_ignore got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_mtc0_drop;
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h0);
    bus.exc_req = 1'b1; bus.exc_code = 1'b1; bus.cur_pc = 32'h500;
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEE0;
    exp_q.push_back(32'h80);
    @(negedge clk);
    bus.exc_req = 1'b0; bus.cp0_wdata = 32'h1234;
    rd(5'd14, d); checks++;
    if (d !== 32'h500) begin errors++; $display("FAIL drop_epc got %h want 00000500", d); end
    @(negedge clk);
    bus.cp0_we = 1'b0;
    wait_idle(n); checks++;
    if (n != 2) begin errors++; $display("FAIL drop_busy_rest got %0d want 2", n); end
    rd(5'd14, d); checks++;
    if (d !== 32'h500) begin errors++; $display("FAIL busy_write_epc got %h want 00000500", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int n;
    mtc0(5'd12, 32'h0);
    bus.exc_req = 1'b1; bus.exc_code = 1'b0; bus.cur_pc = 32'h700;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h80);
    @(negedge clk);
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_first_len got %0d want 3", n); end
    @(negedge clk);
    bus.exc_req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got busy=%b want 1", bus.busy); end
    wait_idle(n); checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_second_len got %0d want 3", n); end
    rd(5'd14, d); checks++;
    if (d !== 32'h700) begin errors++; $display("FAIL b2b_epc got %h want 00000700", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    @(negedge clk);
    bus.exc_req = 1'b1; bus.cur_pc = 32'h600;
    @(negedge clk);
    bus.exc_req = 1'b0;
    checks++;
    if (bus.flush !== 1'b1) begin errors++; $display("FAIL rstmid_flush got %b want 1", bus.flush); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.flush, bus.redirect_valid, bus.busy, bus.status_exl} !== 4'b0 || bus.redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got f=%b rv=%b b=%b exl=%b pc=%h want all 0",
               bus.flush, bus.redirect_valid, bus.busy, bus.status_exl, bus.redirect_pc);
    end
    rd(5'd14, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rstmid_epc got %h want 0", d); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.exc_req = 1'b0; bus.exc_code = 1'b0; bus.cur_pc = '0; bus.irq = 1'b0; bus.eret = 1'b0;
    bus.cp0_we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0;
    test_reset;
    test_overflow;
    test_eret;
    test_irq;
    test_simultaneous;
    test_nested;
    test_mtc0_drop;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_redirects got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
